// File: rtl/irq_enc_pkg.sv
// rtl/irq_enc_pkg.sv - shared constants for the 8-to-3 interrupt encoder
package irq_enc_pkg;
  localparam int N_SRC  = 8;
  localparam int CODE_W = 3;
endpackage

// File: rtl/irq_encoder_8to3_if.sv
// rtl/irq_encoder_8to3_if.sv - request capture and code handshake bundle
interface irq_encoder_8to3_if;
  import irq_enc_pkg::*;

  logic              en;
  logic [N_SRC-1:0]  in;
  logic              ready;
  logic [CODE_W-1:0] out;
  logic              valid;
  logic [N_SRC-1:0]  pending;
  logic              overflow;

  modport master (
    output en, in, ready,
    input  out, valid, pending, overflow
  );

  modport slave (
    input  en, in, ready,
    output out, valid, pending, overflow
  );
endinterface

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - combinational 8-bit priority encoder
module prio_enc8
  import irq_enc_pkg::*;
#(
  parameter int PRIO_HIGH = 1
) (
  input  logic [N_SRC-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Scan toward the highest-priority end so that bit overwrites the rest.
  always_comb begin
    idx = '0;
    any = |vec;
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_encoder_8to3.sv
// rtl/irq_encoder_8to3.sv - pending-request register with handshaked index output
module irq_encoder_8to3
  import irq_enc_pkg::*;
#(
  parameter int PRIO_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst,
  irq_encoder_8to3_if.slave bus
);

  logic [N_SRC-1:0]  pending_q;
  logic [CODE_W-1:0] out_q;
  logic              valid_q;
  logic              overflow_q;

  logic              accept;
  logic [N_SRC-1:0]  clr_mask;
  logic [N_SRC-1:0]  set_mask;
  logic [N_SRC-1:0]  remain;
  logic [CODE_W-1:0] enc_idx;
  logic              enc_any;

  // The encoder sees only registered requests minus the one being accepted,
  // so a same-cycle re-request is presented again a cycle later.
  always_comb begin
    accept   = valid_q & bus.ready;
    clr_mask = '0;
    if (accept) clr_mask[out_q] = 1'b1;
    set_mask = bus.en ? bus.in : '0;
    remain   = pending_q & ~clr_mask;
  end

  prio_enc8 #(
    .PRIO_HIGH (PRIO_HIGH)
  ) u_prio (
    .vec (remain),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= remain | set_mask;
      if (|(set_mask & remain)) overflow_q <= 1'b1;
      if (!valid_q || accept) begin
        valid_q <= enc_any;
        out_q   <= enc_idx;
      end
    end
  end

  assign bus.out      = out_q;
  assign bus.valid    = valid_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// tb/tb_irq_encoder_8to3.sv - self-checking bench for irq_encoder_8to3
module tb_irq_encoder_8to3;
  import irq_enc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  irq_encoder_8to3_if bus ();

  irq_encoder_8to3 #(.PRIO_HIGH(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state, advanced once per rising edge from the request/accept rules.
  logic [7:0] m_pending;
  int         m_out;
  logic       m_valid;
  logic       m_ovf;

  task automatic model_step();
    logic [7:0] keep;
    logic       acc;
    int         pick;
    if (rst) begin
      m_pending = 8'h00;
      m_out     = 0;
      m_valid   = 1'b0;
      m_ovf     = 1'b0;
    end else begin
      acc  = m_valid && bus.ready;
      keep = m_pending;
      if (acc) keep[m_out] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (bus.en && bus.in[i] && keep[i]) m_ovf = 1'b1;
      end
      m_pending = keep | (bus.en ? bus.in : 8'h00);
      if (!m_valid || acc) begin
        pick = -1;
        for (int i = 7; i >= 0; i--) begin
          if (pick < 0 && keep[i]) pick = i;
        end
        m_valid = (pick >= 0);
        m_out   = (pick >= 0) ? pick : 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] d, input logic rdy);
    rst       = r;
    bus.en    = e;
    bus.in    = d;
    bus.ready = rdy;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 8'hFF, 1'b1);
    tick();
    checks += 4;
    if (bus.pending !== 8'h00) begin errors++; $display("FAIL reset_pending got=%h exp=00", bus.pending); end
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    if (bus.out !== 3'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", bus.out); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_idle_encode();
    drive(1'b0, 1'b1, 8'b0010_0000, 1'b0);
    tick();
    checks += 2;
    if (bus.pending !== 8'h20) begin errors++; $display("FAIL idle_pending got=%h exp=20", bus.pending); end
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL idle_latency_valid got=%b exp=0", bus.valid); end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checks += 3;
    if (bus.pending !== 8'h20) begin errors++; $display("FAIL idle_pending2 got=%h exp=20", bus.pending); end
    if (bus.valid !== 1'b1) begin errors++; $display("FAIL idle_valid got=%b exp=1", bus.valid); end
    if (bus.out !== 3'd5) begin errors++; $display("FAIL idle_out got=%0d exp=5", bus.out); end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checks += 2;
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL idle_drain_valid got=%b exp=0", bus.valid); end
    if (bus.pending !== 8'h00) begin errors++; $display("FAIL idle_drain_pending got=%h exp=00", bus.pending); end
  endtask

  task automatic test_priority_drain();
    int exp_seq [3];
    exp_seq[0] = 7; exp_seq[1] = 2; exp_seq[2] = 0;
    drive(1'b0, 1'b1, 8'b1000_0101, 1'b1);
    tick();
    checks += 1;
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL drain_ready_ignored got=%b exp=0", bus.valid); end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks += 2;
      if (bus.valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got=%b exp=1", k, bus.valid); end
      if (int'(bus.out) != exp_seq[k]) begin errors++; $display("FAIL drain_out[%0d] got=%0d exp=%0d", k, bus.out, exp_seq[k]); end
    end
    tick();
    checks += 2;
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL drain_end_valid got=%b exp=0", bus.valid); end
    if (bus.pending !== 8'h00) begin errors++; $display("FAIL drain_end_pending got=%h exp=00", bus.pending); end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 8'h04, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h80, 1'b0);
    tick();
    checks += 2;
    if (bus.out !== 3'd2) begin errors++; $display("FAIL hold_out got=%0d exp=2", bus.out); end
    if (bus.pending !== 8'h84) begin errors++; $display("FAIL hold_pending got=%h exp=84", bus.pending); end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checks += 1;
    if (bus.out !== 3'd2 || bus.valid !== 1'b1) begin errors++; $display("FAIL hold_stable got=%0d/%b exp=2/1", bus.out, bus.valid); end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    checks += 2;
    if (bus.out !== 3'd7) begin errors++; $display("FAIL hold_next_out got=%0d exp=7", bus.out); end
    if (bus.pending !== 8'h80) begin errors++; $display("FAIL hold_next_pending got=%h exp=80", bus.pending); end
    tick();
    checks += 1;
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL hold_empty_valid got=%b exp=0", bus.valid); end
  endtask

  task automatic test_set_wins_overflow();
    drive(1'b0, 1'b1, 8'h08, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checks += 1;
    if (bus.out !== 3'd3 || bus.valid !== 1'b1) begin errors++; $display("FAIL setwins_pre got=%0d/%b exp=3/1", bus.out, bus.valid); end
    drive(1'b0, 1'b1, 8'h08, 1'b1);
    tick();
    checks += 2;
    if (bus.pending !== 8'h08) begin errors++; $display("FAIL setwins_pending got=%h exp=08", bus.pending); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL setwins_overflow got=%b exp=0", bus.overflow); end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checks += 1;
    if (bus.out !== 3'd3 || bus.valid !== 1'b1) begin errors++; $display("FAIL setwins_repost got=%0d/%b exp=3/1", bus.out, bus.valid); end
    drive(1'b0, 1'b1, 8'h08, 1'b0);
    tick();
    checks += 1;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b exp=1", bus.overflow); end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checks += 1;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_enable_reset();
    drive(1'b0, 1'b0, 8'hFF, 1'b0);
    tick();
    checks += 1;
    if (bus.pending !== 8'h08) begin errors++; $display("FAIL enable_hold got=%h exp=08", bus.pending); end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checks += 3;
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", bus.valid); end
    if (bus.pending !== 8'h00) begin errors++; $display("FAIL midreset_pending got=%h exp=00", bus.pending); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow got=%b exp=0", bus.overflow); end
    drive(1'b0, 1'b1, 8'h02, 1'b0);
    tick();
    checks += 1;
    if (bus.pending !== 8'h02) begin errors++; $display("FAIL resume_pending got=%h exp=02", bus.pending); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int n = 0; n < 400; n++) begin
      d = 8'($urandom) & 8'($urandom);
      drive(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), d,
            ($urandom_range(0, 2) != 0));
      tick();
      checks += 4;
      if (bus.pending !== m_pending) begin errors++; $display("FAIL rand_pending[%0d] got=%h exp=%h", n, bus.pending, m_pending); end
      if (bus.valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got=%b exp=%b", n, bus.valid, m_valid); end
      if (int'(bus.out) != m_out) begin errors++; $display("FAIL rand_out[%0d] got=%0d exp=%0d", n, bus.out, m_out); end
      if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow[%0d] got=%b exp=%b", n, bus.overflow, m_ovf); end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_pending = 8'h00;
    m_out     = 0;
    m_valid   = 1'b0;
    m_ovf     = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    test_reset();
    test_idle_encode();
    test_priority_drain();
    test_hold();
    test_set_wins_overflow();
    test_enable_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_encoder_8to3.md
IRQ_ENCODER_8TO3 -- requirements
Module: irq_encoder_8to3

Interface
REQ-001 SHALL provide parameter PRIO_HIGH, default 1, meaning bit 7 is highest priority (0: bit 0 highest).
REQ-002 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port en  input  1  capture enable for in.
REQ-005 SHALL provide port in  input  8  request lines, one bit per source, sampled each cycle.
REQ-006 SHALL provide port ready  input  1  consumer accepts current code.
REQ-007 SHALL provide port out  output  3  registered binary index of presented request.
REQ-008 SHALL provide port valid  output  1  out holds a pending request index.
REQ-009 SHALL provide port pending  output  8  registered pending-request vector.
REQ-010 SHALL provide port overflow  output  1  sticky flag: a request arrived for an already-pending bit.

Function
REQ-011 SHALL, when en=1, set pending[i] on the edge after in[i]=1 is sampled; when en=0, SHALL ignore in and hold pending.
REQ-012 SHALL define accept as valid=1 and ready=1 on a rising edge.
REQ-013 SHALL, on accept, clear pending[out]; if in[out]=1 and en=1 that same cycle, set wins and the bit stays pending.
REQ-014 SHALL, when valid=0 or on accept, load out/valid from the priority encode of (pending with any accepted bit cleared); in bits sampled that cycle are excluded.
REQ-015 SHALL set valid=1 if that encode input is non-zero, else valid=0 and out=0.
REQ-016 SHALL select the highest-priority set bit per PRIO_HIGH.
REQ-017 SHALL hold out and valid stable while valid=1 and ready=0, even if a higher-priority bit becomes pending.
REQ-018 SHALL therefore give latency: in sampled at edge N -> pending at N -> valid/out at N+1 (idle case).
REQ-019 SHALL support back-to-back accepts: with ready held at 1, one distinct code per cycle until pending is empty.
REQ-020 SHALL set overflow when en=1, in[i]=1 and pending[i]=1 with pending[i] not being cleared that cycle; overflow clears only on reset.
REQ-021 SHALL ignore ready while valid=0.
REQ-022 SHALL keep en independent of the handshake: accepts proceed with en=0.

Reset
REQ-023 SHALL, with rst=1 at an edge, force pending=8'h00, out=3'b000, valid=0, overflow=0, overriding en, in and ready.
REQ-024 SHALL discard any in-flight, unaccepted code when reset is asserted mid-operation; no accept is reported.
REQ-025 SHALL resume capture on the first edge after rst deasserts.

Structure
REQ-026 SHALL place constants N_SRC=8 and CODE_W=3 in shared package irq_enc_pkg.
REQ-027 SHALL implement priority selection in one combinational sub-module prio_enc8 (8-bit vector in, 3-bit index plus any-bit flag out, PRIO_HIGH parameter).
REQ-028 SHALL keep all registers (pending, out, valid, overflow) in irq_encoder_8to3.

Verification
REQ-029 SHALL verify reset: rst=1 with in=8'hFF, en=1 -> pending=8'h00, valid=0, out=0, overflow=0.
REQ-030 SHALL verify idle encode: en=1, in=8'b0010_0000 for one cycle, ready=0 -> one cycle later pending=8'h20, valid=1, out=3'd5.
REQ-031 SHALL verify priority drain: in=8'b1000_0101 (PRIO_HIGH=1), ready=1 -> out sequence 7, 2, 0 on consecutive cycles, then valid=0, pending=8'h00.
REQ-032 SHALL verify hold: valid=1, out=2, ready=0, in=8'h80 -> out stays 2; after ready=1 accept -> out=7.
REQ-033 SHALL verify set-wins and overflow: accept of out=3 while in=8'h08, en=1 -> pending[3] stays 1, valid=1, out=3, overflow stays 0; a second in=8'h08 while pending[3]=1 and no accept -> overflow=1.
REQ-034 SHALL verify enable and mid-operation reset: en=0, in=8'hFF -> pending unchanged; then rst=1 while valid=1 -> next edge valid=0, pending=8'h00.
